// File: rtl/find_extreme_pipe.sv
// find_extreme_pipe
//
// Finds the minimum or maximum of NCH packed channel samples through a
// registered binary comparator tree (one level per cycle, LAT = log2(NCH)
// cycles of latency, one sample per cycle). A frame stage then tracks the
// extreme over all samples of a frame delimited by in_first / in_last.
//
// Parameters
//   WIDTH  sample width in bits
//   NCH    channel count, power of two, 2..64
//   SIGNED 0 = unsigned compare, 1 = two's-complement compare
//   CNT_W  width of the per-frame sample counter
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   din           channel k in bits [k*WIDTH +: WIDTH]
//   in_valid      din / mode / in_first / in_last valid this cycle
//   mode          0 = minimum, 1 = maximum (travels with its sample)
//   in_first      sample opens a frame
//   in_last       sample closes a frame
//   out_valid     per-sample result valid, LAT cycles after in_valid
//   out_value     per-sample extreme across channels (held when not valid)
//   out_index     channel of out_value (lowest channel wins ties)
//   frame_valid   one-cycle pulse, one cycle after the frame's last out_valid
//   frame_value   extreme over the whole frame (held between pulses)
//   frame_index   channel of frame_value
//   frame_sample  ordinal of the sample that held frame_value (0 = first)
module find_extreme_pipe #(
  parameter int  WIDTH  = 16,
  parameter int  NCH    = 8,
  parameter int  SIGNED = 0,
  parameter int  CNT_W  = 16,
  localparam int LAT    = $clog2(NCH),
  localparam int IDX_W  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic                 in_valid,
  input  logic                 mode,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_value,
  output logic [IDX_W-1:0]     out_index,
  output logic                 frame_valid,
  output logic [WIDTH-1:0]     frame_value,
  output logic [IDX_W-1:0]     frame_index,
  output logic [CNT_W-1:0]     frame_sample
);

  // True when a is strictly better than b for the requested direction.
  function automatic logic better(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic             want_max);
    logic a_gt;
    logic a_lt;
    if (SIGNED != 0) begin
      a_gt = $signed(a) > $signed(b);
      a_lt = $signed(a) < $signed(b);
    end else begin
      a_gt = a > b;
      a_lt = a < b;
    end
    return want_max ? a_gt : a_lt;
  endfunction

  // ---------------------------------------------------------------------
  // Comparator tree
  // ---------------------------------------------------------------------
  // Nodes are stored level by level: leaves 0..NCH-1, then each registered
  // level in turn, root last at 2*NCH-2.
  logic [WIDTH-1:0] node_val [2*NCH-1];
  logic [IDX_W-1:0] node_idx [2*NCH-1];

  // Per-stage sideband; bit 0 is the tree input, bit LAT the tree output.
  logic [LAT:1] vld_q, mode_q, first_q, last_q;
  logic [LAT:0] vld_s, mode_s, first_s, last_s;

  assign vld_s   = {vld_q,   in_valid};
  assign mode_s  = {mode_q,  mode};
  assign first_s = {first_q, in_first};
  assign last_s  = {last_q,  in_last};

  for (genvar g = 0; g < NCH; g++) begin : g_leaf
    assign node_val[g] = din[g*WIDTH +: WIDTH];
    assign node_idx[g] = IDX_W'(g);
  end

  for (genvar l = 1; l <= LAT; l++) begin : g_lvl
    localparam int SRC = 2*NCH - ((2*NCH) >> (l-1));  // first node of level l-1
    localparam int DST = 2*NCH - ((2*NCH) >> l);      // first node of level l

    for (genvar n = 0; n < (NCH >> l); n++) begin : g_node
      localparam int LO = SRC + 2*n;
      localparam int HI = LO + 1;

      logic [WIDTH-1:0] val_q;
      logic [IDX_W-1:0] idx_q;
      logic             take_hi;

      // The low input always covers lower channels, so it keeps ties.
      assign take_hi = better(node_val[HI], node_val[LO], mode_s[l-1]);

      // NOTE: node data is reset as well because the root doubles as
      // out_value, which must read 0 after reset; the registers only load
      // on a valid stage so bubbles leave the previous result in place.
      always_ff @(posedge clk) begin
        if (reset) begin
          val_q <= '0;
          idx_q <= '0;
        end else if (vld_s[l-1]) begin
          val_q <= take_hi ? node_val[HI] : node_val[LO];
          idx_q <= take_hi ? node_idx[HI] : node_idx[LO];
        end
      end

      assign node_val[DST + n] = val_q;
      assign node_idx[DST + n] = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= '0;
      mode_q  <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      vld_q   <= vld_s[LAT-1:0];
      mode_q  <= mode_s[LAT-1:0];
      first_q <= first_s[LAT-1:0];
      last_q  <= last_s[LAT-1:0];
    end
  end

  assign out_valid = vld_s[LAT];
  assign out_value = node_val[2*NCH-2];
  assign out_index = node_idx[2*NCH-2];

  // ---------------------------------------------------------------------
  // Frame accumulator
  // ---------------------------------------------------------------------
  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_val_q, acc_val_d;
  logic [IDX_W-1:0] acc_idx_q, acc_idx_d;
  logic [CNT_W-1:0] acc_smp_q, acc_smp_d;
  logic             acc_mode_q, acc_mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             frame_load;

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a signal unassigned and no latch is inferred; blocking
  // assignments are correct here, the registers below use non-blocking.
  always_comb begin
    state_d    = state_q;
    acc_val_d  = acc_val_q;
    acc_idx_d  = acc_idx_q;
    acc_smp_d  = acc_smp_q;
    acc_mode_d = acc_mode_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    frame_load = 1'b0;

    if (vld_s[LAT]) begin
      if (first_s[LAT]) begin
        // Opens a frame; in ACCUM this silently abandons the open one.
        acc_val_d  = out_value;
        acc_idx_d  = out_index;
        acc_smp_d  = '0;
        acc_mode_d = mode_s[LAT];
        cnt_d      = CNT_W'(1);
        state_d    = ACCUM;
        accept     = 1'b1;
      end else if (state_q == ACCUM) begin
        // Strict compare: an earlier sample keeps a tie. cnt_q is the
        // ordinal of the current sample.
        if (better(out_value, acc_val_q, acc_mode_q)) begin
          acc_val_d = out_value;
          acc_idx_d = out_index;
          acc_smp_d = cnt_q;
        end
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        accept = 1'b1;
      end

      if (accept && last_s[LAT]) begin
        frame_load = 1'b1;
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_val_q    <= '0;
      acc_idx_q    <= '0;
      acc_smp_q    <= '0;
      acc_mode_q   <= 1'b0;
      cnt_q        <= '0;
      frame_valid  <= 1'b0;
      frame_value  <= '0;
      frame_index  <= '0;
      frame_sample <= '0;
    end else begin
      state_q     <= state_d;
      acc_val_q   <= acc_val_d;
      acc_idx_q   <= acc_idx_d;
      acc_smp_q   <= acc_smp_d;
      acc_mode_q  <= acc_mode_d;
      cnt_q       <= cnt_d;
      frame_valid <= frame_load;
      if (frame_load) begin
        frame_value  <= acc_val_d;
        frame_index  <= acc_idx_d;
        frame_sample <= acc_smp_d;
      end
    end
  end

endmodule

// File: tb/tb_find_extreme_pipe.sv
// Testbench for find_extreme_pipe (NCH=4, WIDTH=16, CNT_W=16).
// Two instances share the stimulus: one unsigned, one signed. A reference
// model scans channels linearly and tracks frames with plain procedural
// code; expected outputs are scheduled by cycle number in a queue.
module tb_find_extreme_pipe;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic          clk;
  logic          reset;
  logic [N*W-1:0] din;
  logic          in_valid;
  logic          mode;
  logic          in_first;
  logic          in_last;

  logic          ov_u, fv_u, ov_s, fv_s;
  logic [W-1:0]  oval_u, fval_u, fsmp_u, oval_s, fval_s, fsmp_s;
  logic [1:0]    oidx_u, fidx_u, oidx_s, fidx_s;

  find_extreme_pipe #(.WIDTH(W), .NCH(N), .SIGNED(0), .CNT_W(16)) u_dut_u (
    .clk(clk), .reset(reset), .din(din), .in_valid(in_valid), .mode(mode),
    .in_first(in_first), .in_last(in_last),
    .out_valid(ov_u), .out_value(oval_u), .out_index(oidx_u),
    .frame_valid(fv_u), .frame_value(fval_u), .frame_index(fidx_u),
    .frame_sample(fsmp_u)
  );

  find_extreme_pipe #(.WIDTH(W), .NCH(N), .SIGNED(1), .CNT_W(16)) u_dut_s (
    .clk(clk), .reset(reset), .din(din), .in_valid(in_valid), .mode(mode),
    .in_first(in_first), .in_last(in_last),
    .out_valid(ov_s), .out_value(oval_s), .out_index(oidx_s),
    .frame_valid(fv_s), .frame_value(fval_s), .frame_index(fidx_s),
    .frame_sample(fsmp_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                 due;
    logic [1:0][W-1:0]  val;   // [0] unsigned, [1] signed
    logic [1:0][1:0]    idx;
    logic               mode;
    logic               first;
    logic               last;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  // Frame model, one per variant
  bit         open_m [2];
  logic       fmode_m[2];
  logic [W-1:0] fval_m[2];
  logic [1:0] fidx_m [2];
  int         fsmp_m [2];
  int         fcnt_m [2];

  bit         pend;
  int         pdue;
  logic [W-1:0] pval[2];
  logic [1:0] pidx [2];
  int         psmp [2];

  // Values the outputs should hold right now
  logic [W-1:0] hval [2];
  logic [1:0]   hidx [2];
  logic [W-1:0] hfval[2];
  logic [1:0]   hfidx[2];
  logic [W-1:0] hfsmp[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit beats(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic mx, input int sgn);
    int ia, ib;
    ia = sgn ? int'($signed(a)) : int'(a);
    ib = sgn ? int'($signed(b)) : int'(b);
    return mx ? (ia > ib) : (ia < ib);
  endfunction

  function automatic logic [N*W-1:0] p4(input logic [W-1:0] c3, input logic [W-1:0] c2,
                                       input logic [W-1:0] c1, input logic [W-1:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  // Linear scan: first channel found keeps ties, i.e. the lowest index.
  task automatic model_scan(input logic [N*W-1:0] d, input logic mx, input int sgn,
                            output logic [W-1:0] v, output logic [1:0] k);
    v = d[W-1:0];
    k = 2'd0;
    for (int c = 1; c < N; c++) begin
      if (beats(d[c*W +: W], v, mx, sgn)) begin
        v = d[c*W +: W];
        k = 2'(c);
      end
    end
  endtask

  task automatic step(input logic v, input logic m, input logic f, input logic l,
                      input logic [N*W-1:0] d, input logic r);
    exp_t e;
    bit   eov;
    bit   efv;
    bit   upd;
    reset = r; in_valid = v; mode = m; in_first = f; in_last = l; din = d;
    @(posedge clk);
    #1;
    cyc++;

    if (r) begin
      q.delete();
      pend = 0;
      for (int s = 0; s < 2; s++) begin
        open_m[s] = 0;
        hval[s] = '0; hidx[s] = '0;
        hfval[s] = '0; hfidx[s] = '0; hfsmp[s] = '0;
      end
    end else if (v) begin
      e.due = cyc + LAT - 1;
      e.mode = m; e.first = f; e.last = l;
      for (int s = 0; s < 2; s++) model_scan(d, m, s, e.val[s], e.idx[s]);
      q.push_back(e);
    end

    efv = pend && (pdue == cyc);
    if (efv) begin
      pend = 0;
      for (int s = 0; s < 2; s++) begin
        hfval[s] = pval[s]; hfidx[s] = pidx[s]; hfsmp[s] = 16'(psmp[s]);
      end
    end

    eov = (q.size() > 0) && (q[0].due == cyc);
    if (eov) begin
      e = q.pop_front();
      for (int s = 0; s < 2; s++) begin
        hval[s] = e.val[s];
        hidx[s] = e.idx[s];
        upd = 0;
        if (e.first) begin
          open_m[s] = 1; fmode_m[s] = e.mode;
          fval_m[s] = e.val[s]; fidx_m[s] = e.idx[s];
          fsmp_m[s] = 0; fcnt_m[s] = 1; upd = 1;
        end else if (open_m[s]) begin
          if (beats(e.val[s], fval_m[s], fmode_m[s], s)) begin
            fval_m[s] = e.val[s]; fidx_m[s] = e.idx[s]; fsmp_m[s] = fcnt_m[s];
          end
          if (fcnt_m[s] < 65535) fcnt_m[s]++;
          upd = 1;
        end
        if (upd && e.last) begin
          open_m[s] = 0;
          pend = 1; pdue = cyc + 1;
          pval[s] = fval_m[s]; pidx[s] = fidx_m[s]; psmp[s] = fsmp_m[s];
        end
      end
    end

    for (int s = 0; s < 2; s++) begin
      chk($sformatf("out_valid[%0d]", s),    s ? ov_s   : ov_u,   eov);
      chk($sformatf("out_value[%0d]", s),    s ? oval_s : oval_u, hval[s]);
      chk($sformatf("out_index[%0d]", s),    s ? oidx_s : oidx_u, hidx[s]);
      chk($sformatf("frame_valid[%0d]", s),  s ? fv_s   : fv_u,   efv);
      chk($sformatf("frame_value[%0d]", s),  s ? fval_s : fval_u, hfval[s]);
      chk($sformatf("frame_index[%0d]", s),  s ? fidx_s : fidx_u, hfidx[s]);
      chk($sformatf("frame_sample[%0d]", s), s ? fsmp_s : fsmp_u, hfsmp[s]);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  logic [W-1:0] bnd [4];

  initial begin
    bnd[0] = 16'h0000; bnd[1] = 16'hFFFF; bnd[2] = 16'h8000; bnd[3] = 16'h7FFF;
    reset = 1'b1; in_valid = 1'b0; mode = 1'b0; in_first = 1'b0; in_last = 1'b0; din = '0;

    // Reset with in_valid high: ignored, all outputs 0
    step(1'b1, 1'b0, 1'b1, 1'b1, p4(1, 2, 3, 4), 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, p4(5, 6, 7, 8), 1'b1);
    idle();
    idle();
    chk("rst_out_valid", ov_u, 1'b0);
    chk("rst_frame_value", fval_u, 16'd0);

    // One-sample frame, minimum of {9,3,7,5}
    step(1'b1, 1'b0, 1'b1, 1'b1, p4(9, 3, 7, 5), 1'b0);
    idle();
    chk("r35_ov", ov_u, 1'b1);
    chk("r35_val", oval_u, 16'd3);
    chk("r35_idx", oidx_u, 2'd2);
    idle();
    chk("r35_fv", fv_u, 1'b1);
    chk("r35_fval", fval_u, 16'd3);
    chk("r35_fsmp", fsmp_u, 16'd0);

    // Back-to-back max then min of {4,4,8,4}
    step(1'b1, 1'b1, 1'b0, 1'b0, p4(4, 4, 8, 4), 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, p4(4, 4, 8, 4), 1'b0);
    chk("r36_max_val", oval_u, 16'd8);
    chk("r36_max_idx", oidx_u, 2'd1);
    idle();
    chk("r36_min_ov", ov_u, 1'b1);
    chk("r36_min_val", oval_u, 16'd4);
    chk("r36_min_idx", oidx_u, 2'd0);
    idle();
    chk("r36_hold_val", oval_u, 16'd4);

    // Three-sample frame, per-sample minima 6, 2, 2
    step(1'b1, 1'b0, 1'b1, 1'b0, p4(6, 9, 9, 9), 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, p4(9, 2, 9, 9), 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, p4(2, 9, 9, 9), 1'b0);
    idle();
    idle();
    chk("r37_fv", fv_u, 1'b1);
    chk("r37_fval", fval_u, 16'd2);
    chk("r37_fidx", fidx_u, 2'd2);
    chk("r37_fsmp", fsmp_u, 16'd1);
    idle();
    chk("r37_single_pulse", fv_u, 1'b0);

    // Signed extreme: 16'h8000 is most negative
    step(1'b1, 1'b0, 1'b1, 1'b1, p4(16'h8000, 16'd1, 16'hFFFF, 16'd0), 1'b0);
    idle();
    chk("r38_sval", oval_s, 16'h8000);
    chk("r38_sidx", oidx_s, 2'd3);
    chk("r38_uval", oval_u, 16'd0);
    chk("r38_uidx", oidx_u, 2'd0);
    idle();

    // Reset with two samples in flight
    step(1'b1, 1'b1, 1'b1, 1'b0, p4(1, 2, 3, 4), 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, p4(5, 6, 7, 8), 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, p4(9, 9, 9, 9), 1'b1);
    chk("r39_ov", ov_u, 1'b0);
    chk("r39_val", oval_u, 16'd0);
    chk("r39_fval_s", fval_s, 16'd0);
    idle();
    idle();
    chk("r39_no_fv", fv_u, 1'b0);
    // First sample after reset is accepted
    step(1'b1, 1'b1, 1'b1, 1'b1, p4(1, 20, 3, 4), 1'b0);
    idle();
    chk("r34_val", oval_u, 16'd20);
    idle();
    chk("r34_fv", fv_u, 1'b1);

    // Frame abandoned by a second in_first; counter restarts at 1
    step(1'b1, 1'b0, 1'b1, 1'b0, p4(5, 5, 5, 5), 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, p4(6, 6, 6, 6), 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, p4(9, 9, 9, 9), 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, p4(8, 8, 8, 8), 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, p4(1, 9, 9, 9), 1'b0);
    idle();
    idle();
    chk("r40_fv", fv_u, 1'b1);
    chk("r40_fval", fval_u, 16'd1);
    chk("r40_fidx", fidx_u, 2'd3);
    chk("r40_fsmp", fsmp_u, 16'd2);

    // Randomized traffic with ties, boundary values and occasional reset
    for (int i = 0; i < 500; i++) begin
      logic [N*W-1:0] d;
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 3))
          0:       d[k*W +: W] = 16'($urandom_range(0, 3));
          1:       d[k*W +: W] = bnd[$urandom_range(0, 3)];
          default: d[k*W +: W] = 16'($urandom);
        endcase
      end
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0),
           d, 1'($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < 4; i++) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
